// File: rtl/param_sync_fifo.sv
// Parametrised single-clock FIFO with exact full/empty flags, almost-full/almost-empty thresholds,
// optional first-word-fall-through read, synchronous flush and sticky overflow/underflow flags.
module param_sync_fifo #(
  parameter int unsigned DATA_WIDTH          = 32,
  parameter int unsigned ADDR_WIDTH          = 4,
  parameter int unsigned ALMOST_FULL_THRESH  = 12,
  parameter int unsigned ALMOST_EMPTY_THRESH = 4,
  parameter bit          FWFT                = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  flush,
  input  logic                  FIFO_WR_EN,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  FIFO_RD_EN,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  read_valid,
  output logic                  FIFO_FULL,
  output logic                  FIFO_EMPTY,
  output logic                  FIFO_ALMOST_FULL,
  output logic                  FIFO_ALMOST_EMPTY,
  output logic [ADDR_WIDTH:0]   fill_count,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clr_err
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned CW    = ADDR_WIDTH + 1;

  localparam logic [ADDR_WIDTH:0] DepthC = CW'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AfThC  = CW'(ALMOST_FULL_THRESH);
  localparam logic [ADDR_WIDTH:0] AeThC  = CW'(ALMOST_EMPTY_THRESH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR_WIDTH:0]   count_q;
  logic                  overflow_q, underflow_q;
  logic                  rd_acc, wr_acc, rd_do, wr_do;

  // A full FIFO still takes a write when a read frees a slot in the same cycle.
  assign rd_acc = FIFO_RD_EN & ~FIFO_EMPTY;
  assign wr_acc = FIFO_WR_EN & (~FIFO_FULL | rd_acc);
  assign rd_do  = rd_acc & ~flush;
  assign wr_do  = wr_acc & ~flush;

  assign fill_count        = count_q;
  assign FIFO_FULL         = (count_q == DepthC);
  assign FIFO_EMPTY        = (count_q == '0);
  assign FIFO_ALMOST_FULL  = (count_q >= AfThC);
  assign FIFO_ALMOST_EMPTY = (count_q <= AeThC);
  assign overflow          = overflow_q;
  assign underflow         = underflow_q;

  always_ff @(posedge clk) begin
    if (wr_do) begin
      mem[wr_ptr_q] <= write_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_do) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_do) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (wr_do && !rd_do) begin
        count_q <= count_q + 1'b1;
      end else if (rd_do && !wr_do) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  // A new error in the same cycle as clr_err keeps the flag set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= (FIFO_WR_EN & ~wr_acc) | (overflow_q & ~clr_err);
      underflow_q <= (FIFO_RD_EN & FIFO_EMPTY) | (underflow_q & ~clr_err);
    end
  end

  if (FWFT) begin : g_fwft
    assign read_data  = mem[rd_ptr_q];
    assign read_valid = ~FIFO_EMPTY;
  end else begin : g_reg
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  rvalid_q;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        rdata_q  <= '0;
        rvalid_q <= 1'b0;
      end else if (rd_do) begin
        rdata_q  <= mem[rd_ptr_q];
        rvalid_q <= 1'b1;
      end else begin
        rvalid_q <= 1'b0;
      end
    end

    assign read_data  = rdata_q;
    assign read_valid = rvalid_q;
  end

endmodule

// File: tb/tb_param_sync_fifo.sv
// Directed bench for param_sync_fifo: a registered-read instance and a FWFT instance share
// clock, reset, flush and clr_err; expected values are hand-derived constants.
module tb_param_sync_fifo;

  logic        clk = 1'b0;
  logic        reset_n, flush, clr_err;

  logic        wr0, rd0, rv0, full0, empty0, af0, ae0, ovf0, unf0;
  logic [31:0] wd0, rdata0;
  logic [4:0]  fill0;

  logic        wr1, rd1, rv1, full1, empty1, af1, ae1, ovf1, unf1;
  logic [31:0] wd1, rdata1;
  logic [4:0]  fill1;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  param_sync_fifo #(.FWFT(1'b0)) u_dut_reg (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .FIFO_WR_EN(wr0), .write_data(wd0), .FIFO_RD_EN(rd0),
    .read_data(rdata0), .read_valid(rv0),
    .FIFO_FULL(full0), .FIFO_EMPTY(empty0),
    .FIFO_ALMOST_FULL(af0), .FIFO_ALMOST_EMPTY(ae0),
    .fill_count(fill0), .overflow(ovf0), .underflow(unf0), .clr_err(clr_err)
  );

  param_sync_fifo #(.FWFT(1'b1)) u_dut_fwft (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .FIFO_WR_EN(wr1), .write_data(wd1), .FIFO_RD_EN(rd1),
    .read_data(rdata1), .read_valid(rv1),
    .FIFO_FULL(full1), .FIFO_EMPTY(empty1),
    .FIFO_ALMOST_FULL(af1), .FIFO_ALMOST_EMPTY(ae1),
    .fill_count(fill1), .overflow(ovf1), .underflow(unf1), .clr_err(clr_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; flush = 1'b0; clr_err = 1'b0;
    wr0 = 1'b0; rd0 = 1'b0; wd0 = '0;
    wr1 = 1'b0; rd1 = 1'b0; wd1 = '0;
    step();

    // Reset state
    check("rst_empty", 32'(empty0), 32'd1);
    check("rst_full", 32'(full0), 32'd0);
    check("rst_ae", 32'(ae0), 32'd1);
    check("rst_af", 32'(af0), 32'd0);
    check("rst_fill", 32'(fill0), 32'd0);
    check("rst_rv", 32'(rv0), 32'd0);
    check("rst_rdata", rdata0, 32'd0);
    check("rst_ovf", 32'(ovf0), 32'd0);
    check("rst_unf", 32'(unf0), 32'd0);
    check("rst_fwft_rv", 32'(rv1), 32'd0);
    #2 reset_n = 1'b1;

    // Fill to 16 with 0x1000..0x100F
    for (int i = 0; i < 16; i++) begin
      wr0 = 1'b1; wd0 = 32'h1000 + 32'(i);
      step();
      check("fill_cnt", 32'(fill0), 32'(i + 1));
      check("fill_af", 32'(af0), 32'((i + 1) >= 12));
      check("fill_ae", 32'(ae0), 32'((i + 1) <= 4));
      check("fill_full", 32'(full0), 32'(i == 15));
      check("fill_empty", 32'(empty0), 32'd0);
    end
    wd0 = 32'hDEAD;
    step();
    wr0 = 1'b0;
    check("ovf_set", 32'(ovf0), 32'd1);
    check("ovf_fill", 32'(fill0), 32'd16);
    pulse_clr();
    check("ovf_clr", 32'(ovf0), 32'd0);

    // Full with simultaneous read/write: both accepted
    wr0 = 1'b1; rd0 = 1'b1; wd0 = 32'hAAAA;
    step();
    wr0 = 1'b0; rd0 = 1'b0;
    check("rw_full_fill", 32'(fill0), 32'd16);
    check("rw_full_ovf", 32'(ovf0), 32'd0);
    check("rw_full_rv", 32'(rv0), 32'd1);
    check("rw_full_data", rdata0, 32'h1000);

    // Drain: 0x1001..0x100F then 0xAAAA
    for (int i = 0; i < 16; i++) begin
      rd0 = 1'b1;
      step();
      check("drain_rv", 32'(rv0), 32'd1);
      check("drain_data", rdata0, (i < 15) ? 32'h1001 + 32'(i) : 32'hAAAA);
      check("drain_fill", 32'(fill0), 32'(15 - i));
      check("drain_empty", 32'(empty0), 32'(i == 15));
    end
    step();
    rd0 = 1'b0;
    check("unf_set", 32'(unf0), 32'd1);
    check("unf_rv", 32'(rv0), 32'd0);
    check("unf_hold", rdata0, 32'hAAAA);
    check("unf_fill", 32'(fill0), 32'd0);
    pulse_clr();
    check("unf_clr", 32'(unf0), 32'd0);

    // FWFT: write becomes visible after the write edge, pop empties it
    wr1 = 1'b1; wd1 = 32'h55;
    step();
    wr1 = 1'b0;
    check("fwft_data", rdata1, 32'h55);
    check("fwft_rv", 32'(rv1), 32'd1);
    check("fwft_empty", 32'(empty1), 32'd0);
    rd1 = 1'b1;
    step();
    rd1 = 1'b0;
    check("fwft_pop_empty", 32'(empty1), 32'd1);
    check("fwft_pop_rv", 32'(rv1), 32'd0);
    check("fwft_pop_unf", 32'(unf1), 32'd0);

    // Pointer wrap at occupancy 3
    for (int i = 0; i < 3; i++) begin
      wr0 = 1'b1; wd0 = 32'h2000 + 32'(i);
      step();
    end
    check("wrap_pre_fill", 32'(fill0), 32'd3);
    for (int i = 0; i < 40; i++) begin
      wr0 = 1'b1; rd0 = 1'b1; wd0 = 32'h2003 + 32'(i);
      step();
      check("wrap_data", rdata0, 32'h2000 + 32'(i));
      check("wrap_fill", 32'(fill0), 32'd3);
    end
    wr0 = 1'b0; rd0 = 1'b0;

    // Flush, refill 5, flush again together with a write
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush1_fill", 32'(fill0), 32'd0);
    for (int i = 0; i < 5; i++) begin
      wr0 = 1'b1; wd0 = 32'h3000 + 32'(i);
      step();
    end
    check("refill_fill", 32'(fill0), 32'd5);
    wd0 = 32'h3333; flush = 1'b1;
    step();
    flush = 1'b0; wr0 = 1'b0;
    check("flush_fill", 32'(fill0), 32'd0);
    check("flush_empty", 32'(empty0), 32'd1);
    check("flush_rv", 32'(rv0), 32'd0);
    check("flush_hold", rdata0, 32'h2027);
    check("flush_ovf", 32'(ovf0), 32'd0);

    // Asynchronous reset mid-burst
    rd1 = 1'b1;
    step();
    rd1 = 1'b0;
    check("pre_rst_unf1", 32'(unf1), 32'd1);
    for (int i = 0; i < 3; i++) begin
      wr0 = 1'b1; wd0 = 32'h4000 + 32'(i);
      step();
    end
    #2 reset_n = 1'b0;
    #1;
    check("arst_fill", 32'(fill0), 32'd0);
    check("arst_empty", 32'(empty0), 32'd1);
    check("arst_ae", 32'(ae0), 32'd1);
    check("arst_full", 32'(full0), 32'd0);
    check("arst_rdata", rdata0, 32'd0);
    check("arst_unf1", 32'(unf1), 32'd0);
    #2 reset_n = 1'b1;
    wd0 = 32'h4444;
    step();
    wr0 = 1'b0;
    check("post_rst_fill", 32'(fill0), 32'd1);
    rd0 = 1'b1;
    step();
    rd0 = 1'b0;
    check("post_rst_data", rdata0, 32'h4444);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
